fetch_controller: RTL
=====================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset (bits [1:0] SHALL be treated as 0).
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous active-low reset (0 = reset asserted).
REQ-004 The block SHALL have port imem_req  output  1  instruction memory read strobe.
REQ-005 The block SHALL have port imem_addr  output  32  byte address of the read; bits [1:0] always 0.
REQ-006 The block SHALL have port imem_rdata  input  32  read data, valid exactly one cycle after the imem_req cycle.
REQ-007 The block SHALL have port branch_valid  input  1  redirect request from execute.
REQ-008 The block SHALL have port branch_target  input  32  redirect byte address.
REQ-009 The block SHALL have port dec_valid  output  1  instruction available to decode.
REQ-010 The block SHALL have port dec_ready  input  1  decode accepts the instruction this cycle.
REQ-011 The block SHALL have port dec_instr  output  32  instruction word at the head of the buffer.
REQ-012 The block SHALL have port dec_pc  output  32  fetch address of dec_instr.

Function
REQ-013 The block SHALL hold a PC register, a 2-entry FIFO of {instr, pc}, an in-flight flag, and a state register with states BOOT, FETCH, STALL.
REQ-014 The block SHALL move BOOT->FETCH on the first rising edge after reset release, with imem_req=0 during BOOT.
REQ-015 The block SHALL define pop = dec_valid & dec_ready, and credit = fifo_count + inflight (range 0..2).
REQ-016 The block SHALL assert imem_req, with imem_addr=PC, iff state!=BOOT, branch_valid=0, and (credit - pop) < 2.
REQ-017 The block SHALL advance PC by 4 on each issued request, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-018 The block SHALL write {imem_rdata, address of that request} into the FIFO in the cycle after an issue, unless that cycle has branch_valid=1.
REQ-019 The block SHALL drive dec_valid = (fifo_count != 0) and dec_instr/dec_pc from the FIFO head (registered; no memory-to-decode bypass), giving 2 cycles from issue to dec_valid.
REQ-020 The block SHALL pop the head when pop=1; simultaneous push and pop SHALL keep the count unchanged and preserve order.
REQ-021 The block SHALL be in STALL when credit=2 and pop=0, and in FETCH otherwise (after BOOT); STALL->FETCH on the first pop.
REQ-022 With dec_ready held at 1, the block SHALL sustain one dec_valid instruction per cycle.
REQ-023 On branch_valid=1 (any state including BOOT) the block SHALL: set PC <= {branch_target[31:2],2'b00}, flush the FIFO, drop any data returning that cycle, clear inflight, suppress imem_req, ignore dec_ready, and enter FETCH.
REQ-024 The block SHALL issue the branch-target request in the cycle after branch_valid, and assert dec_valid with dec_pc=target 3 cycles after the branch cycle.
REQ-025 The block SHALL hold dec_instr/dec_pc stable while dec_valid=1 and dec_ready=0.
REQ-026 The block SHALL never overflow (push with count=2) or underflow the FIFO; the verification bench SHALL check both with assertions.

Reset
REQ-027 While rst=0 the block SHALL immediately force: state=BOOT, PC=RESET_PC, fifo_count=0, inflight=0, imem_req=0, imem_addr=RESET_PC, dec_valid=0, dec_instr=0, dec_pc=0.
REQ-028 Reset asserted mid-operation SHALL discard all buffered and in-flight instructions; the first fetch after release SHALL be at RESET_PC.

Verification
REQ-029 Boot: release rst, dec_ready=1, memory returns addr-encoded words -> imem_req first in cycle 2 at 0x0, dec_valid in cycle 4 with dec_pc=0x0, then 0x4, 0x8 on consecutive cycles.
REQ-030 Backpressure: dec_ready=0 from cycle 4 -> at most 2 instructions buffered, STALL entered, imem_req=0, dec_pc held at 0x0; dec_ready=1 -> 0x0, 0x4, 0x8 delivered in order with no gap or duplicate.
REQ-031 Branch: branch_valid=1, target 0x103 while the FIFO is full -> dec_valid=0 next cycle, imem_addr=0x100 one cycle later, dec_pc=0x100 3 cycles after the branch.
REQ-032 Branch with response in flight: branch the cycle after an issue at 0x8 -> the 0x8 word is never presented to decode.
REQ-033 Wrap: RESET_PC=0xFFFF_FFF8 -> dec_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-034 Async reset: assert rst between clock edges while the FIFO holds 2 entries -> dec_valid=0 and imem_req=0 before the next edge; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_controller.sv
// Instruction fetch front end: PC sequencing, one-deep memory pipeline
// and a 2-entry {instr, pc} buffer feeding decode, with branch redirect.
module fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc
);

    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] STALL = 2'd2;

    localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};

    logic [1:0]  state;
    logic [31:0] pc;
    logic        inflight;
    logic [31:0] inflight_pc;
    logic [1:0]  count;
    logic [31:0] head_instr;
    logic [31:0] head_pc;
    logic [31:0] tail_instr;
    logic [31:0] tail_pc;

    logic        pop;
    logic        push;
    logic        issue;
    logic [1:0]  credit;

    // credit counts slots already promised: buffered plus the one in flight
    assign credit = count + {1'b0, inflight};
    assign pop    = dec_valid & dec_ready & ~branch_valid;
    assign push   = inflight & ~branch_valid;
    assign issue  = (state != BOOT) & ~branch_valid
                  & ((credit - {1'b0, pop}) < 2'd2);

    assign imem_req  = issue;
    assign imem_addr = pc;
    assign dec_valid = (count != 2'd0);
    assign dec_instr = head_instr;
    assign dec_pc    = head_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= BOOT;
            pc          <= START_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
            count       <= 2'd0;
            head_instr  <= 32'h0;
            head_pc     <= 32'h0;
            tail_instr  <= 32'h0;
            tail_pc     <= 32'h0;
        end else if (branch_valid) begin
            state    <= FETCH;
            pc       <= {branch_target[31:2], 2'b00};
            inflight <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (state == BOOT)
                state <= FETCH;
            else if (credit == 2'd2 && !pop)
                state <= STALL;
            else
                state <= FETCH;

            inflight <= issue;
            if (issue) begin
                pc          <= pc + 32'd4;
                inflight_pc <= pc;
            end

            count <= count + {1'b0, push} - {1'b0, pop};

            // head is always the oldest entry; tail only used when count=2
            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_instr <= imem_rdata;
                        head_pc    <= inflight_pc;
                    end else begin
                        tail_instr <= imem_rdata;
                        tail_pc    <= inflight_pc;
                    end
                end
                2'b01: begin
                    head_instr <= tail_instr;
                    head_pc    <= tail_pc;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head_instr <= imem_rdata;
                        head_pc    <= inflight_pc;
                    end else begin
                        head_instr <= tail_instr;
                        head_pc    <= tail_pc;
                        tail_instr <= imem_rdata;
                        tail_pc    <= inflight_pc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
